// File: rtl/scu_pkg.sv
// SCU shared definitions: register masks/reset values, interrupt level table,
// priority-selector result type and interrupt FSM state encoding.
package scu_pkg;

    localparam logic [15:0] IMS_WMASK  = 16'hBFFF;
    localparam logic [15:0] IMS_INIT   = 16'hBFFF;
    localparam logic [31:0] IST_RMASK  = 32'hFFFF3FFF;
    localparam logic [31:0] IST_INIT   = 32'h0000_0000;
    localparam logic        AIACK_INIT = 1'b0;

    // Entries 0..13: internal sources (IST[13:0]); entries 14..29: A-bus sources 0..15.
    localparam logic [29:0][3:0] INT_LEVEL = {
        {8{4'h1}}, {4{4'h4}}, {4{4'h7}},
        4'h2, 4'h3, 4'h5, 4'h6, 4'h6, 4'h8, 4'h8,
        4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
    };

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic [3:0] idx;
        logic [3:0] lvl;
    } scu_int_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_ACKED  = 2'd2
    } scu_int_state_t;

endpackage

// File: rtl/scu_int_prio.sv
// Combinational priority selector over the 14 internal and 16 external candidates.
module scu_int_prio
    import scu_pkg::*;
(
    input  logic [13:0]  cand_int,
    input  logic [15:0]  cand_ext,
    output scu_int_sel_t sel
);

    // Strictly-greater replacement scanning internal then external, low index first,
    // so ties resolve to the lowest index with internal ahead of external.
    always_comb begin
        sel = '0;
        for (int unsigned n = 0; n < 14; n++) begin
            if (cand_int[n] && (!sel.valid || INT_LEVEL[n] > sel.lvl)) begin
                sel.valid = 1'b1;
                sel.ext   = 1'b0;
                sel.idx   = 4'(n);
                sel.lvl   = INT_LEVEL[n];
            end
        end
        for (int unsigned n = 0; n < 16; n++) begin
            if (cand_ext[n] && (!sel.valid || INT_LEVEL[14 + n] > sel.lvl)) begin
                sel.valid = 1'b1;
                sel.ext   = 1'b1;
                sel.idx   = 4'(n);
                sel.lvl   = INT_LEVEL[14 + n];
            end
        end
    end

endmodule

// File: rtl/scu_int_ctrl.sv
// SCU interrupt controller: IMS/IST/AIACK registers, source latching, and the
// IRL/vector handshake towards the master SH-2.
module scu_int_ctrl
    import scu_pkg::*;
#(
    parameter logic [7:0] VEC_INT = 8'h40,
    parameter logic [7:0] VEC_EXT = 8'h50
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic [13:0] INT_PULSE,
    input  logic [15:0] EXT_REQ,
    input  logic        IMS_WR,
    input  logic        IST_WR,
    input  logic        AIACK_WR,
    input  logic [31:0] REG_DI,
    output logic [15:0] IMS_Q,
    output logic [31:0] IST_Q,
    output logic        AIACK_Q,
    output logic [3:0]  IRL,
    output logic [7:0]  VEC,
    input  logic        IACK
);

    scu_int_state_t state_q, state_d;
    logic [15:0]    ims_q, ims_d;
    logic [31:0]    ist_q, ist_d;
    logic           aiack_q, aiack_d;
    logic [3:0]     irl_q, irl_d;
    logic [7:0]     vec_q, vec_d;
    scu_int_sel_t   sel_q, sel_d;

    scu_int_sel_t   sel;
    logic [13:0]    cand_int;
    logic [15:0]    cand_ext;
    logic [31:0]    ack_clr;
    logic           ack_ext;
    logic [7:0]     sel_vec;

    assign cand_int = ist_q[13:0] & ~ims_q[13:0];
    assign cand_ext = ist_q[31:16] & {16{~ims_q[15]}};

    scu_int_prio u_prio (
        .cand_int (cand_int),
        .cand_ext (cand_ext),
        .sel      (sel)
    );

    assign sel_vec = (sel.ext ? VEC_EXT : VEC_INT) + {4'h0, sel.idx};

    // Handshake FSM: IRL/VEC follow the best candidate, ack clears the presented source.
    always_comb begin
        state_d = state_q;
        irl_d   = irl_q;
        vec_d   = vec_q;
        sel_d   = sel_q;
        ack_clr = '0;
        ack_ext = 1'b0;
        case (state_q)
            ST_IDLE: begin
                irl_d = '0;
                vec_d = '0;
                if (sel.valid) begin
                    state_d = ST_ASSERT;
                    irl_d   = sel.lvl;
                    vec_d   = sel_vec;
                    sel_d   = sel;
                end
            end
            ST_ASSERT: begin
                if (IACK) begin
                    // The acknowledged source is the one registered onto IRL, not the live pick.
                    ack_clr[{sel_q.ext, sel_q.idx}] = 1'b1;
                    ack_ext = sel_q.ext;
                    irl_d   = '0;
                    vec_d   = '0;
                    state_d = ST_ACKED;
                end else if (sel.valid) begin
                    irl_d = sel.lvl;
                    vec_d = sel_vec;
                    sel_d = sel;
                end else begin
                    irl_d   = '0;
                    vec_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ACKED: begin
                irl_d   = '0;
                vec_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                irl_d   = '0;
                vec_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register bank next-state: new events override same-cycle write/ack clears.
    always_comb begin
        ims_d = ims_q;
        if (IMS_WR) begin
            ims_d = (ims_q & ~IMS_WMASK) | (REG_DI[15:0] & IMS_WMASK);
        end
        ist_d = ((ist_q & (IST_WR ? REG_DI : '1) & ~ack_clr)
                | {EXT_REQ & {16{aiack_q}}, 2'b00, INT_PULSE}) & IST_RMASK;
        aiack_d = aiack_q;
        if (ack_ext) begin
            aiack_d = 1'b0;
        end
        if (AIACK_WR) begin
            aiack_d = REG_DI[0];
        end
    end

    // State registers, advancing only on clock-enable cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ims_q   <= IMS_INIT;
            ist_q   <= IST_INIT;
            aiack_q <= AIACK_INIT;
            irl_q   <= '0;
            vec_q   <= '0;
            sel_q   <= '0;
        end else if (CE) begin
            state_q <= state_d;
            ims_q   <= ims_d;
            ist_q   <= ist_d;
            aiack_q <= aiack_d;
            irl_q   <= irl_d;
            vec_q   <= vec_d;
            sel_q   <= sel_d;
        end
    end

    assign IMS_Q   = ims_q;
    assign IST_Q   = ist_q;
    assign AIACK_Q = aiack_q;
    assign IRL     = irl_q;
    assign VEC     = vec_q;

endmodule

// File: tb/tb_scu_int_ctrl.sv
// Directed bench for scu_int_ctrl with hand-computed expected values.
module tb_scu_int_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CE;
    logic [13:0] INT_PULSE;
    logic [15:0] EXT_REQ;
    logic        IMS_WR;
    logic        IST_WR;
    logic        AIACK_WR;
    logic [31:0] REG_DI;
    logic [15:0] IMS_Q;
    logic [31:0] IST_Q;
    logic        AIACK_Q;
    logic [3:0]  IRL;
    logic [7:0]  VEC;
    logic        IACK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    scu_int_ctrl #(.VEC_INT(8'h40), .VEC_EXT(8'h50)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CE        (CE),
        .INT_PULSE (INT_PULSE),
        .EXT_REQ   (EXT_REQ),
        .IMS_WR    (IMS_WR),
        .IST_WR    (IST_WR),
        .AIACK_WR  (AIACK_WR),
        .REG_DI    (REG_DI),
        .IMS_Q     (IMS_Q),
        .IST_Q     (IST_Q),
        .AIACK_Q   (AIACK_Q),
        .IRL       (IRL),
        .VEC       (VEC),
        .IACK      (IACK)
    );

    always #5 CLK = ~CLK;

    // Compare one observed value against its expected value and log a mismatch.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_ims(input logic [31:0] d);
        IMS_WR = 1'b1; REG_DI = d; tick(); IMS_WR = 1'b0; REG_DI = '0;
    endtask

    task automatic write_ist(input logic [31:0] d);
        IST_WR = 1'b1; REG_DI = d; tick(); IST_WR = 1'b0; REG_DI = '0;
    endtask

    task automatic write_aiack(input logic [31:0] d);
        AIACK_WR = 1'b1; REG_DI = d; tick(); AIACK_WR = 1'b0; REG_DI = '0;
    endtask

    task automatic pulse(input logic [13:0] p);
        INT_PULSE = p; tick(); INT_PULSE = '0;
    endtask

    task automatic ack();
        IACK = 1'b1; tick(); IACK = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; CE = 1'b1; INT_PULSE = '0; EXT_REQ = '0;
        IMS_WR = 1'b0; IST_WR = 1'b0; AIACK_WR = 1'b0; REG_DI = '0; IACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_ims",   32'(IMS_Q),   32'h0000_BFFF);
        check_eq("rst_ist",   IST_Q,        32'h0);
        check_eq("rst_aiack", 32'(AIACK_Q), 32'h0);
        check_eq("rst_irl",   32'(IRL),     32'h0);
        check_eq("rst_vec",   32'(VEC),     32'h0);
        RST_N = 1'b1;
        tick();

        // 1: masked VBII latches into IST but never reaches IRL
        pulse(14'h0001);
        check_eq("t1_ist", IST_Q, 32'h1);
        tick();
        check_eq("t1_irl", 32'(IRL), 32'h0);
        write_ist(32'h0);
        check_eq("t1_clr", IST_Q, 32'h0);

        // 2: unmasked VBII, latency one cycle, then ack with two IRL=0 cycles
        write_ims(32'h0000_BFFE);
        check_eq("t2_ims", 32'(IMS_Q), 32'h0000_BFFE);
        pulse(14'h0001);
        check_eq("t2_irl_lat", 32'(IRL), 32'h0);
        tick();
        check_eq("t2_irl", 32'(IRL), 32'hF);
        check_eq("t2_vec", 32'(VEC), 32'h40);
        ack();
        check_eq("t2_ack_ist", IST_Q, 32'h0);
        check_eq("t2_ack_irl0", 32'(IRL), 32'h0);
        tick();
        check_eq("t2_ack_irl1", 32'(IRL), 32'h0);

        // 3: T1I (bit4, lvl B) and DII (bit12, lvl 3) together
        write_ims(32'h0);
        check_eq("t3_ims", 32'(IMS_Q), 32'h0);
        pulse(14'h1010);
        tick();
        check_eq("t3_irl_a", 32'(IRL), 32'hB);
        check_eq("t3_vec_a", 32'(VEC), 32'h44);
        ack();
        check_eq("t3_ist_a", IST_Q, 32'h1000);
        check_eq("t3_gap0", 32'(IRL), 32'h0);
        tick();
        check_eq("t3_gap1", 32'(IRL), 32'h0);
        tick();
        check_eq("t3_irl_b", 32'(IRL), 32'h3);
        check_eq("t3_vec_b", 32'(VEC), 32'h4C);
        ack();
        check_eq("t3_ist_b", IST_Q, 32'h0);
        tick(); tick();

        // tie at level 8: bit7 beats bit8
        pulse(14'h0180);
        tick();
        check_eq("tie_irl", 32'(IRL), 32'h8);
        check_eq("tie_vec", 32'(VEC), 32'h47);
        ack();
        check_eq("tie_ist", IST_Q, 32'h100);
        tick(); tick();
        check_eq("tie_vec2", 32'(VEC), 32'h48);
        write_ist(32'h0);
        tick();
        check_eq("vanish_irl", 32'(IRL), 32'h0);

        // 4: external gating by AIACK
        EXT_REQ = 16'h0010;
        tick();
        check_eq("t4_blocked", IST_Q, 32'h0);
        write_aiack(32'h1);
        check_eq("t4_aiack", 32'(AIACK_Q), 32'h1);
        tick();
        check_eq("t4_ist", IST_Q, 32'h0010_0000);
        tick();
        check_eq("t4_irl", 32'(IRL), 32'h4);
        check_eq("t4_vec", 32'(VEC), 32'h54);
        EXT_REQ = 16'h0;
        ack();
        check_eq("t4_aiack_clr", 32'(AIACK_Q), 32'h0);
        check_eq("t4_ist_clr", IST_Q, 32'h0);
        EXT_REQ = 16'h0001;
        tick(); tick();
        check_eq("t4_ext0_block", IST_Q, 32'h0);
        write_aiack(32'h1);
        tick();
        check_eq("t4_ext0_ist", IST_Q, 32'h0001_0000);
        tick();
        check_eq("t4_ext0_irl", 32'(IRL), 32'h7);
        check_eq("t4_ext0_vec", 32'(VEC), 32'h50);
        EXT_REQ = 16'h0;
        write_ist(32'h0);
        tick();
        check_eq("t4_vanish", 32'(IRL), 32'h0);
        write_aiack(32'h0);

        // 5: preemption and set-wins against an IST clear write
        pulse(14'h0200);
        tick();
        check_eq("t5_irl6", 32'(IRL), 32'h6);
        check_eq("t5_vec49", 32'(VEC), 32'h49);
        INT_PULSE = 14'h0001; IST_WR = 1'b1; REG_DI = 32'hFFFF_FFFE;
        tick();
        INT_PULSE = '0; IST_WR = 1'b0; REG_DI = '0;
        check_eq("t5_setwins", IST_Q, 32'h0000_0201);
        check_eq("t5_irl_hold", 32'(IRL), 32'h6);
        tick();
        check_eq("t5_preempt_irl", 32'(IRL), 32'hF);
        check_eq("t5_preempt_vec", 32'(VEC), 32'h40);

        // 6: async reset mid-handshake
        #2 RST_N = 1'b0;
        #1;
        check_eq("t6_irl", 32'(IRL), 32'h0);
        check_eq("t6_ist", IST_Q, 32'h0);
        check_eq("t6_ims", 32'(IMS_Q), 32'h0000_BFFF);
        RST_N = 1'b1;
        ack();
        check_eq("t6_iack_irl", 32'(IRL), 32'h0);
        check_eq("t6_iack_ist", IST_Q, 32'h0);

        // clock enable low freezes all state
        CE = 1'b0;
        IMS_WR = 1'b1; REG_DI = 32'h0; INT_PULSE = 14'h0002;
        tick();
        IMS_WR = 1'b0; INT_PULSE = '0;
        check_eq("ce_ims", 32'(IMS_Q), 32'h0000_BFFF);
        check_eq("ce_ist", IST_Q, 32'h0);
        CE = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
